// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared, external,
// combinational ALU and returns each result through a valid/ready response.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (ready is combinational)
//   reqN_a, reqN_b, reqN_op    operands and 3-bit opcode of requester N
//   alu_a, alu_b, alu_op       registered operands/opcode driven to the shared ALU
//   alu_out                    combinational result from the shared ALU
//   resp_valid/ready           response handshake
//   resp_data, resp_id         result and the requester it belongs to
//   resp_err                   opcode 111 was rejected
//   busy                       FSM is not IDLE
//
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// Without it, requester 0 wins every simultaneous request.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_id_q, resp_id_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_valid_q, busy_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  logic             grant0_c, grant1_c, xfer_c;
  logic [WIDTH-1:0] sel_a_c, sel_b_c;
  logic [2:0]       sel_op_c;

  // Arbitration: requester 1 wins when alone, or on a tie when 0 was served last.
  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    grant1_c = req1_valid && (!req0_valid || !last_q);
`else
    grant1_c = req1_valid && !req0_valid;
`endif
    grant0_c   = req0_valid && !grant1_c;
    req0_ready = (state_q == IDLE) && grant0_c;
    req1_ready = (state_q == IDLE) && grant1_c;
    xfer_c     = req0_ready || req1_ready;
    sel_a_c    = grant1_c ? req1_a  : req0_a;
    sel_b_c    = grant1_c ? req1_b  : req0_b;
    sel_op_c   = grant1_c ? req1_op : req0_op;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          resp_id_d = grant1_c;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_d    = grant1_c;
`endif
          if (sel_op_c == OP_ILLEGAL) begin
            // Rejected op skips the ALU entirely; operand registers keep old values.
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end else begin
            alu_a_d  = sel_a_c;
            alu_b_d  = sel_b_c;
            alu_op_d = sel_op_c;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        resp_data_d = alu_out;
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'b000;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= (state_d == RESP);
      busy_q       <= (state_d != IDLE);
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;

endmodule
